// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op codes are also used by the decoder.
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with MTHI/MTLO; 32 iterations plus
// one sign-fixup cycle, sharing one 33-bit adder/subtractor.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q;
  logic [4:0]         cnt_q;
  md_op_e             op_q;
  logic               neg_q;
  logic               rsgn_q;
  logic               dz_q;
  logic [WIDTH-1:0]   ma_q;
  logic [WIDTH-1:0]   mb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               is_div;
  logic               sgn_in;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     add_x;
  logic [WIDTH:0]     add_y;
  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign sgn_in = (op == MD_MULT) || (op == MD_DIV);

  // Divide: acc high half is the quotient, low half the remainder.
  assign rem_sh = {acc_q[WIDTH-1:0], ma_q[5'(WIDTH-1) - cnt_q]};

  always_comb begin
    add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y = mb_q[cnt_q] ? {1'b0, ma_q} : '0;
    if (is_div) begin
      add_x = rem_sh;
      add_y = {1'b0, mb_q};
    end
    add_s = add_x + (is_div ? ~add_y : add_y)
          + {{WIDTH{1'b0}}, is_div};
  end

  always_comb begin
    acc_d = {add_s, acc_q[WIDTH-1:1]};
    if (is_div) begin
      acc_d = {acc_q[2*WIDTH-2:WIDTH], ~add_s[WIDTH],
               add_s[WIDTH] ? rem_sh[WIDTH-1:0] : add_s[WIDTH-1:0]};
    end
  end

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      res_hi = rsgn_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      if (dz_q) begin
        res_hi = rsgn_q ? -ma_q : ma_q;
        res_lo = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      neg_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      dz_q    <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            ma_q    <= mag32(a, sgn_in);
            mb_q    <= mag32(b, sgn_in);
            op_q    <= md_op_e'(op);
            neg_q   <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsgn_q  <= sgn_in & a[WIDTH-1];
            dz_q    <= op[1] && (b == '0);
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end else begin
            if (hi_wr) hi_q <= wdata;
            if (lo_wr) lo_q <= wdata;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(MD_ITER - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle
// compare, directed literal cases and randomized operations.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns {HI, LO} straight from integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [1:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          q = sx / sy;
          r = sx % sy;
          return {r[31:0], q[31:0]};
        end
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= 33;
        m_res  <= ref_op(op, a, b);
      end else begin
        if (hi_wr) m_hi <= wdata;
        if (lo_wr) m_lo <= wdata;
      end
    end else begin
      m_done <= 1'b0;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_hi   <= m_res[63:32];
        m_lo   <= m_res[31:0];
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input string nm, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, x, y);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'd33);
    chk({nm, "_hi"}, hi, ehi);
    chk({nm, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_wr = 1'b0; lo_wr = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    run("multu_max", 2'd1, '1, '1, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_m1", 2'd0, '1, '1, 32'd0, 32'd1);
    run("div_m7", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_7", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    run("div_ovf", 2'd2, 32'h8000_0000, '1, 32'd0, 32'h8000_0000);
    run("divu_z", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run("div_z", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    repeat (5) @(negedge clk);
    op = 2'd3; start = 1'b1; hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    wait_done(n);
    chk("ign_hi", hi, 32'hFFFF_FFFF);
    chk("ign_lo", lo, 32'hFFFF_FFFA);

    @(negedge clk);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h1234);

    op = 2'd3; a = 32'd7; b = 32'd2; start = 1'b1;
    hi_wr = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    chk("sw_hi_hold", hi, 32'h1234);
    wait_done(n);
    chk("sw_hi", hi, 32'd1);
    chk("sw_lo", lo, 32'd3);

    @(negedge clk);
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    run("mult_6x7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 9));
        2: ry = '1;
        default: ry = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) rx = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) begin
        hi_wr = 1'($urandom);
        lo_wr = 1'($urandom);
        wdata = $urandom;
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b0;
      end
      issue(ro, rx, ry);
      wait_done(n);
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath, providing the MULT, MULTU, DIV, DIVU, MTHI and MTLO instructions.
- Sits beside the ALU, directly downstream of the register file read ports.
- Its HI/LO outputs feed the register write-back mux for MFHI/MFLO.
- Each operation runs one bit per cycle over 32 cycles, plus one sign-fixup cycle.
- The decoder stalls the PC on `busy`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width. Only 32 is supported.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: launch operation `op`. Sampled only in IDLE.
- `op`, in, 2: operation, encoded as MULT=00, MULTU=01, DIV=10, DIVU=11.
- `a`, in, 32: rs operand (register file port 1); the dividend or multiplicand.
- `b`, in, 32: rt operand (register file port 2); the divisor or multiplier.
- `hi_wr`, in, 1: MTHI. Write `wdata` into HI.
- `lo_wr`, in, 1: MTLO. Write `wdata` into LO.
- `wdata`, in, 32: MTHI/MTLO data.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse when HI/LO take a new result.
- `hi`, out, 32: HI register.
- `lo`, out, 32: LO register.

## Operation
State machine with states IDLE, CALC, FIX.

IDLE:
- `start`=1: latch the magnitudes of `a` and `b` (two's-complement absolute value for signed ops; raw value for unsigned ops). Latch `op`, the result signs and the divide-by-zero flag. Clear the accumulator and iteration counter. Go to CALC.
- `start` has priority over `hi_wr`/`lo_wr` in the same cycle; those writes are dropped.
- `start`=0: `hi_wr` writes HI and `lo_wr` writes LO on the same edge. Both may be set together.

CALC, 32 iterations, counter 0..31:
- Multiply: shift-add. The 64-bit product accumulator takes one multiplier bit per cycle, LSB first.
- Divide: restoring division. The remainder is shifted left one dividend bit, MSB first. Subtract the divisor when the 33-bit difference is non-negative; the quotient bit is 1 when the subtraction succeeds.
- At counter 31, go to FIX.

FIX:
- Apply signs.
  - Signed MULT: negate the 64-bit product if sign(a) XOR sign(b).
  - Signed DIV: quotient negated if sign(a) XOR sign(b); remainder takes the sign of `a`.
- Multiply results: HI = product[63:32], LO = product[31:0].
- Divide results: HI = remainder, LO = quotient.
- Divide by zero (`b`=0, DIV or DIVU): HI = `a` unmodified, LO = 32'hFFFFFFFF. The full latency is kept.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- Pulse `done`, return to IDLE.

General rules:
- `start`, `hi_wr` and `lo_wr` are ignored while `busy`=1. The CPU must stall on `busy`.
- Operands are latched at start. Changes to `a` and `b` during CALC have no effect.

## Timing
- `start` sampled at edge k:
  - `busy`=1 after edge k.
  - Iterations on edges k+1 .. k+32.
  - FIX on edge k+33: HI/LO updated, `done`=1, `busy`=0.
- Latency is 33 cycles, fixed for every op, including divide by zero.
- `done` lasts exactly one cycle. A new `start` is accepted in that same cycle.
- MTHI/MTLO: HI/LO updated on the edge where the write is sampled; one-cycle latency.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Reset mid-operation: immediate return to the reset values. No `done` is produced and partial results are discarded.
- HI/LO hold their values during CALC. Old values stay readable until FIX.

## Structure
- Shared package `mdu_pkg`:
  - Op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State enum.
  - Constant MD_ITER=32.
- The decoder imports `mdu_pkg` for the op codes.
- Single module, no sub-modules. The datapath is the accumulator/remainder register plus one 33-bit adder/subtractor shared between multiply and divide.

## Test plan
- MULT a=0xFFFFFFFE, b=3 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` one cycle, `busy` high cycles k+1..k+33.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
  - Then MULT same operands -> HI=0, LO=1.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 -> LO=3, HI=1.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF after 33 cycles.
  - DIV 0xFFFFFFF9/0 -> HI=0xFFFFFFF9, LO=0xFFFFFFFF.
- While busy, assert `start` (op=DIVU), `hi_wr`, `lo_wr` with wdata=0x1234 -> all ignored; the original result completes.
  - In IDLE, `hi_wr`+`lo_wr` with wdata=0x1234 -> HI=LO=0x1234 next edge.
  - `start`+`hi_wr` together in IDLE -> HI unchanged until the result arrives.
- `rst` asserted at k+10 of a MULT -> `busy`=0, HI=LO=0, no `done`.
  - A new MULT 6*7 afterwards -> LO=42, HI=0.
